// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetcher with a single-outstanding req/ack memory port
// feeding a DEPTH-entry {pc+4, inst} FIFO. Optional macro FQ_B2B_EN enables back-to-back requests.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTRW     = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    input  logic            deq,
    output logic            out_valid,
    output logic [31:0]     out_inst,
    output logic [31:0]     out_pc4,
    output logic [PTRW:0]   count,
    output logic            mem_req,
    output logic [31:0]     mem_addr,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic [1:0]      dbg_state
);

    // Handshake: mem_req rises with mem_addr and both hold stable until the cycle mem_ack=1;
    // that cycle completes the transfer. deq is a single-cycle pop of the head entry.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [PTRW:0]   FULL_CNT = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
`ifdef FQ_B2B_EN
    localparam logic [PTRW:0]   ALMOST_CNT = (PTRW+1)'(DEPTH - 1);
`endif

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW:0]   count_q, count_d;
    logic [31:0]     inst_mem [DEPTH];
    logic [31:0]     pc4_mem  [DEPTH];

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [31:0]     redirect_pc_al;
    logic [31:0]     pc_plus4;

    assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4       = fetch_pc_q + 32'd4;
    assign fifo_empty     = (count_q == '0);
    assign fifo_full      = (count_q == FULL_CNT);
    assign pop            = deq && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end else if (!fifo_full) begin
                    state_d = S_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (mem_ack && !redirect) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_plus4;
                    state_d    = S_IDLE;
`ifdef FQ_B2B_EN
                    // The slot for the next request must already be free once this push lands.
                    if (pop || (count_q < ALMOST_CNT)) begin
                        state_d = S_WAIT;
                        addr_d  = pc_plus4;
                    end
`endif
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                    state_d    = mem_ack ? S_IDLE : S_DROP;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: reads are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= mem_rdata;
            pc4_mem[wr_ptr_q]  <= pc_plus4;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_inst  = fifo_empty ? 32'd0 : inst_mem[rd_ptr_q];
    assign out_pc4   = fifo_empty ? 32'd0 : pc4_mem[rd_ptr_q];
    assign count     = count_q;
    assign mem_req   = (state_q != S_IDLE);
    assign mem_addr  = addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a transaction-level
// model (FIFO as a queue, one outstanding request tracked by address and a stale flag).
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          PTRW     = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FQ_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            deq;
    logic            out_valid;
    logic [31:0]     out_inst;
    logic [31:0]     out_pc4;
    logic [PTRW:0]   count;
    logic            mem_req;
    logic [31:0]     mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_rdata;
    logic [1:0]      dbg_state;

    fetch_queue #(.DEPTH(DEPTH), .PTRW(PTRW), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc4(out_pc4), .count(count),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_next_pc;
    logic [31:0] m_req_addr;
    logic        m_req;
    logic        m_stale;
    int          lat_mode;
    int          mem_wait;
    int          req_cycles;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int pick_wait();
        case (lat_mode)
            0:       return 0;
            1:       return 1;
            2:       return int'($urandom_range(0, 3));
            default: return 1_000_000;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_next_pc = RESET_PC;
        m_req     = 1'b0;
        m_stale   = 1'b0;
    endtask

    task automatic new_request();
        m_req      = 1'b1;
        m_req_addr = m_next_pc;
        m_stale    = 1'b0;
        mem_wait   = pick_wait();
    endtask

    task automatic compare_all();
        logic [63:0] head;
        check_eq("mem_req", 64'(mem_req), 64'(m_req));
        if (m_req) check_eq("mem_addr", 64'(mem_addr), 64'(m_req_addr));
        check_eq("count", 64'(count), 64'(exp_q.size()));
        check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check_eq("out_inst", 64'(out_inst), 64'(head[31:0]));
            check_eq("out_pc4", 64'(out_pc4), 64'(head[63:32]));
        end else begin
            check_eq("out_inst_empty", 64'(out_inst), 64'd0);
            check_eq("out_pc4_empty", 64'(out_pc4), 64'd0);
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, then check after the next edge.
    task automatic run_cycle(input logic rd, input logic [31:0] rpc, input logic dq);
        logic        pop_e;
        logic        accept;
        logic [63:0] entry;
        int          sz;
        redirect    = rd;
        redirect_pc = rpc;
        deq         = dq;
        mem_ack     = 1'b0;
        if (mem_req && mem_wait == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
        end else if (mem_req) begin
            mem_wait--;
        end

        sz     = exp_q.size();
        pop_e  = dq && (sz > 0);
        accept = 1'b0;
        entry  = '0;
        if (m_req) begin
            if (rd) m_stale = 1'b1;
            if (mem_ack) begin
                accept = !m_stale;
                if (accept) begin
                    entry     = {m_req_addr + 32'd4, mem_rdata};
                    m_next_pc = m_req_addr + 32'd4;
                end
                m_req = 1'b0;
                if (B2B && accept && (sz + 1 - int'(pop_e)) < DEPTH) new_request();
            end
        end else if (!rd && sz < DEPTH) begin
            new_request();
        end
        if (pop_e) void'(exp_q.pop_front());
        if (accept) exp_q.push_back(entry);
        if (rd) begin
            exp_q.delete();
            m_next_pc = rpc & 32'hFFFF_FFFC;
        end

        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 8 && !mem_req; i++) run_cycle(1'b0, 32'd0, 1'b0);
        check_eq(tag, 64'(mem_req), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 12 && !out_valid; i++) run_cycle(1'b0, 32'd0, 1'b0);
        check_eq(tag, 64'(out_valid), 64'd1);
    endtask

    initial begin
        int deq_pct;
        logic        rd;
        logic [31:0] rpc;
        logic        dq;

        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        lat_mode = 1; mem_wait = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        check_eq("reset_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;

        // Fill with a one-wait memory and no consumer.
        for (int i = 0; i < 16; i++) run_cycle(1'b0, 32'd0, 1'b0);
        check_eq("fill_count", 64'(count), 64'd4);
        check_eq("fill_no_req", 64'(mem_req), 64'd0);
        check_eq("fill_head_pc4", 64'(out_pc4), 64'd4);

        // One pop from full frees a slot for address 16; memory then stalls.
        lat_mode = 3;
        run_cycle(1'b0, 32'd0, 1'b1);
        check_eq("pop_count", 64'(count), 64'd3);
        wait_req("pop_req_seen");
        check_eq("pop_next_addr", 64'(mem_addr), 64'h10);

        // Redirect while waiting; the late ack must be discarded.
        run_cycle(1'b1, 32'h40, 1'b0);
        check_eq("redir_flush", 64'(count), 64'd0);
        check_eq("redir_old_addr", 64'(mem_addr), 64'h10);
        run_cycle(1'b0, 32'd0, 1'b0);
        run_cycle(1'b0, 32'd0, 1'b0);
        lat_mode = 1;
        mem_wait = 0;
        run_cycle(1'b0, 32'd0, 1'b0);
        check_eq("drop_discard", 64'(count), 64'd0);
        wait_req("redir_req_seen");
        check_eq("redir_addr", 64'(mem_addr), 64'h40);
        wait_valid("redir_valid_seen");
        check_eq("redir_pc4", 64'(out_pc4), 64'h44);

        // Redirect coincident with ack.
        wait_req("coinc_req_seen");
        mem_wait = 0;
        run_cycle(1'b1, 32'h100, 1'b0);
        check_eq("coinc_count", 64'(count), 64'd0);
        check_eq("coinc_idle", 64'(mem_req), 64'd0);
        run_cycle(1'b0, 32'd0, 1'b0);
        check_eq("coinc_addr", 64'(mem_addr), 64'h100);

        // Unaligned redirect near the top of memory; fetch_pc+4 wraps to 0.
        run_cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
        run_cycle(1'b0, 32'd0, 1'b0);
        run_cycle(1'b0, 32'd0, 1'b0);
        check_eq("wrap_addr", 64'(mem_addr), 64'hFFFF_FFFC);
        wait_valid("wrap_valid_seen");
        check_eq("wrap_pc4", 64'(out_pc4), 64'd0);
        wait_req("wrap_req_seen");
        check_eq("wrap_next_addr", 64'(mem_addr), 64'd0);

        // Asynchronous reset in the middle of an outstanding request.
        lat_mode = 3;
        mem_wait = 1_000_000;
        run_cycle(1'b0, 32'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_req", 64'(mem_req), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_valid", 64'(out_valid), 64'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        check_eq("arst_ack_ignored", 64'(count), 64'd0);
        rst = 1'b0;
        mem_ack = 1'b0;
        model_reset();
        lat_mode = 1;
        compare_all();
        run_cycle(1'b0, 32'd0, 1'b0);
        check_eq("arst_first_addr", 64'(mem_addr), 64'(RESET_PC));

        // Zero-wait memory with a consumer that takes every cycle.
        lat_mode = 0;
        mem_wait = 0;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 32'd0, 1'b1);
        req_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (mem_req) req_cycles++;
            run_cycle(1'b0, 32'd0, 1'b1);
        end
        check_eq("throughput", 64'(req_cycles), B2B ? 64'd16 : 64'd8);

        // Randomized traffic.
        for (int seg = 0; seg < 30; seg++) begin
            lat_mode = int'($urandom_range(0, 2));
            deq_pct  = int'($urandom_range(10, 90));
            for (int i = 0; i < 100; i++) begin
                rd  = ($urandom_range(0, 15) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
                dq  = (int'($urandom_range(1, 100)) <= deq_pct);
                run_cycle(rd, rpc, dq);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
